// File: rtl/mmcm_drp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_drp_pkg : shared types and clock profiles for the MMCM DRP sequencer |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mmcm_drp_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_RST_HOLD  = 4'd1,
        ST_RD_REQ    = 4'd2,
        ST_RD_WAIT   = 4'd3,
        ST_WR_REQ    = 4'd4,
        ST_WR_WAIT   = 4'd5,
        ST_REL       = 4'd6,
        ST_LOCK_WAIT = 4'd7,
        ST_DONE      = 4'd8,
        ST_ERR       = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BAD_SEL = 2'd1,
        ERR_DRDY_TO = 2'd2,
        ERR_LOCK_TO = 2'd3
    } err_code_t;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] keep_mask;
        logic [15:0] data;
    } drp_entry_t;

    localparam int C_PROFILE_COUNT = 2;
    localparam int C_PROFILE_REGS  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // VCO = 1000 MHz (FB x10). Profile 0: CLKOUT1 /50, CLKOUT2 /5; profile 1: /40, /10.
    function automatic drp_entry_t profile_entry(input logic [3:0] sel, input logic [4:0] idx);
        drp_entry_t e;
        e = '0;
        case (idx)
            5'd0: e = (sel == 4'd0) ? {7'h0A, 16'h1000, 16'h0659} : {7'h0A, 16'h1000, 16'h0514};
            5'd1: e = {7'h0B, 16'hFC00, 16'h0000};
            5'd2: e = (sel == 4'd0) ? {7'h0C, 16'h1000, 16'h0083} : {7'h0C, 16'h1000, 16'h0145};
            5'd3: e = (sel == 4'd0) ? {7'h0D, 16'hFC00, 16'h0080} : {7'h0D, 16'hFC00, 16'h0000};
            5'd4: e = {7'h14, 16'h1000, 16'h0145};
            5'd5: e = {7'h15, 16'hFC00, 16'h0000};
            5'd6: e = {7'h18, 16'hFC00, 16'h00FA};
            5'd7: e = {7'h4E, 16'h66FF, 16'h0800};
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmcm_drp_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_drp_rom : combinational (profile, index) -> DRP entry lookup         |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
module mmcm_drp_rom
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_CFG  = 2,
    parameter int NUM_REGS = 8
) (
    input  logic [3:0] sel,
    input  logic [4:0] idx,
    output drp_entry_t entry
);

    // Slots beyond the stored profiles read as zero so an oversized parameter set stays benign.
    always_comb begin
        entry = '0;
        if (({28'd0, sel} < NUM_CFG) && ({27'd0, idx} < NUM_REGS) &&
            ({28'd0, sel} < C_PROFILE_COUNT) && ({27'd0, idx} < C_PROFILE_REGS)) begin
            entry = profile_entry(sel, idx);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmcm_drp_reconfig_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mmcm_drp_reconfig_ctrl : MMCM reset + DRP read-modify-write reprogrammer  |
// | Revision               : 1.0                                              |
// +--------------------------------------------------------------------------+
module mmcm_drp_reconfig_ctrl
    import mmcm_drp_pkg::*;
#(
    parameter int NUM_CFG      = 2,
    parameter int NUM_REGS     = 8,
    parameter int RST_HOLD     = 16,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        sysClk_i,
    input  logic        sysRst_i,
    input  logic        cfgReq_i,
    input  logic [3:0]  cfgSel_i,
    output logic        cfgBusy_o,
    output logic        cfgDone_o,
    output logic        cfgErr_o,
    output logic [1:0]  cfgErrCode_o,
    output logic        mmcmRst_o,
    input  logic        mmcmLocked_i,
    output logic        drpDen_o,
    output logic        drpDwe_o,
    output logic [6:0]  drpDaddr_o,
    output logic [15:0] drpDi_o,
    input  logic [15:0] drpDo_i,
    input  logic        drpDrdy_i
);

    localparam int C_CNT_MAX = max3(RST_HOLD, DRDY_TIMEOUT, LOCK_TIMEOUT);
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    state_t               r_state;
    state_t               w_next;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [4:0]           r_idx;
    logic [3:0]           r_sel;
    logic [15:0]          r_rdata;
    err_code_t            r_err_code;
    logic                 r_lock_meta;
    logic                 r_lock_sync;
    drp_entry_t           w_entry;
    logic                 w_sel_ok;
    logic                 w_last;
    logic                 w_hold_done;
    logic                 w_drdy_to;
    logic                 w_lock_to;

    assign w_sel_ok    = ({28'd0, cfgSel_i} < NUM_CFG);
    assign w_last      = (r_idx == 5'(NUM_REGS - 1));
    assign w_hold_done = (r_cnt == C_CNT_W'(RST_HOLD - 1));
    assign w_drdy_to   = (r_cnt == C_CNT_W'(DRDY_TIMEOUT - 1));
    assign w_lock_to   = (r_cnt == C_CNT_W'(LOCK_TIMEOUT - 1));

    mmcm_drp_rom #(
        .NUM_CFG  (NUM_CFG),
        .NUM_REGS (NUM_REGS)
    ) u_rom (
        .sel   (r_sel),
        .idx   (r_idx),
        .entry (w_entry)
    );

    always_ff @(posedge sysClk_i) begin
        if (sysRst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // DRDY is checked before the timeout so a response on the expiry cycle still wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (cfgReq_i) w_next = w_sel_ok ? ST_RST_HOLD : ST_ERR;
            ST_RST_HOLD:  if (w_hold_done) w_next = ST_RD_REQ;
            ST_RD_REQ:    w_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (drpDrdy_i)      w_next = ST_WR_REQ;
                else if (w_drdy_to) w_next = ST_ERR;
            end
            ST_WR_REQ:    w_next = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (drpDrdy_i)      w_next = w_last ? ST_REL : ST_RD_REQ;
                else if (w_drdy_to) w_next = ST_ERR;
            end
            ST_REL:       w_next = ST_LOCK_WAIT;
            ST_LOCK_WAIT: begin
                if (r_lock_sync)    w_next = ST_DONE;
                else if (w_lock_to) w_next = ST_ERR;
            end
            ST_DONE:      w_next = ST_IDLE;
            ST_ERR:       w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk_i) begin
        if (sysRst_i) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_sel       <= '0;
            r_rdata     <= '0;
            r_err_code  <= ERR_NONE;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= mmcmLocked_i;
            r_lock_sync <= r_lock_meta;

            // One counter serves every wait: restarted on each state change, saturating otherwise.
            if (r_state != w_next) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == ST_IDLE && cfgReq_i && w_sel_ok) begin
                r_sel <= cfgSel_i;
            end

            if (r_state == ST_RST_HOLD) begin
                r_idx <= '0;
            end else if (r_state == ST_WR_WAIT && drpDrdy_i && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end

            if (r_state == ST_RD_WAIT && drpDrdy_i) begin
                r_rdata <= drpDo_i;
            end

            if (r_state == ST_IDLE && cfgReq_i) begin
                r_err_code <= w_sel_ok ? ERR_NONE : ERR_BAD_SEL;
            end else if (w_next == ST_ERR && r_state != ST_ERR) begin
                r_err_code <= (r_state == ST_LOCK_WAIT) ? ERR_LOCK_TO : ERR_DRDY_TO;
            end
        end
    end

    always_comb begin
        cfgBusy_o  = 1'b0;
        cfgDone_o  = 1'b0;
        cfgErr_o   = 1'b0;
        mmcmRst_o  = 1'b0;
        drpDen_o   = 1'b0;
        drpDwe_o   = 1'b0;
        drpDaddr_o = '0;
        drpDi_o    = '0;
        case (r_state)
            ST_RST_HOLD, ST_RD_WAIT, ST_WR_WAIT: begin
                cfgBusy_o = 1'b1;
                mmcmRst_o = 1'b1;
            end
            ST_RD_REQ: begin
                cfgBusy_o  = 1'b1;
                mmcmRst_o  = 1'b1;
                drpDen_o   = 1'b1;
                drpDaddr_o = w_entry.addr;
            end
            ST_WR_REQ: begin
                cfgBusy_o  = 1'b1;
                mmcmRst_o  = 1'b1;
                drpDen_o   = 1'b1;
                drpDwe_o   = 1'b1;
                drpDaddr_o = w_entry.addr;
                drpDi_o    = (r_rdata & w_entry.keep_mask) | (w_entry.data & ~w_entry.keep_mask);
            end
            ST_REL, ST_LOCK_WAIT: cfgBusy_o = 1'b1;
            ST_DONE:              cfgDone_o = 1'b1;
            ST_ERR:               cfgErr_o  = 1'b1;
            default: ;
        endcase
    end

    assign cfgErrCode_o = r_err_code;

endmodule
`default_nettype wire
